// File: rtl/queue_2x5_ctrl.sv
// Ready/valid FIFO controller for a 2x5 dual-port RAM (sync write, gated combinational read).
// Latency: one cycle enq->deq (zero with FLOW into an empty queue); backpressure: enq_ready = !full, independent of deq_ready.
module queue_2x5_ctrl #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 2,
    parameter int AW    = $clog2(DEPTH),
    parameter bit FLOW  = 1'b0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [WIDTH-1:0] enq_bits,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [WIDTH-1:0] deq_bits,
    output logic [AW:0]      count,
    output logic [AW-1:0]    ram_W0_addr,
    output logic             ram_W0_en,
    output logic [WIDTH-1:0] ram_W0_data,
    output logic [AW-1:0]    ram_R0_addr,
    output logic             ram_R0_en,
    input  logic [WIDTH-1:0] ram_R0_data
);

    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0] enq_ptr_q, enq_ptr_d;
    logic [AW-1:0] deq_ptr_q, deq_ptr_d;
    logic          maybe_full_q, maybe_full_d;

    logic          ptr_match, empty, full;
    logic          enq_fire, deq_fire, do_enq, do_deq;
    logic [AW-1:0] ptr_diff;

    always_comb begin
        ptr_match = (enq_ptr_q == deq_ptr_q);
        empty     = ptr_match && !maybe_full_q;
        full      = ptr_match && maybe_full_q;

        enq_ready = !full;
        deq_valid = !empty || (FLOW && enq_valid);
        enq_fire  = enq_valid && enq_ready;
        deq_fire  = deq_valid && deq_ready;

        ram_W0_addr = enq_ptr_q;
        ram_W0_data = enq_bits;
        // A bypassed word never touches storage, so it must not be written either.
        ram_W0_en   = enq_fire && !(FLOW && empty && deq_ready);

        ram_R0_addr = deq_ptr_q;
        ram_R0_en   = !empty;
        deq_bits    = (FLOW && empty) ? enq_bits : ram_R0_data;

        ptr_diff = enq_ptr_q - deq_ptr_q;
        count    = full ? DEPTH_CNT : {1'b0, ptr_diff};

        do_enq = ram_W0_en;
        do_deq = deq_fire && !empty;

        enq_ptr_d    = do_enq ? enq_ptr_q + AW'(1) : enq_ptr_q;
        deq_ptr_d    = do_deq ? deq_ptr_q + AW'(1) : deq_ptr_q;
        maybe_full_d = (do_enq != do_deq) ? do_enq : maybe_full_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            enq_ptr_q    <= '0;
            deq_ptr_q    <= '0;
            maybe_full_q <= 1'b0;
        end else begin
            enq_ptr_q    <= enq_ptr_d;
            deq_ptr_q    <= deq_ptr_d;
            maybe_full_q <= maybe_full_d;
        end
    end

endmodule

// File: tb/tb_queue_2x5_ctrl.sv
module tb_queue_2x5_ctrl;

    logic       clock = 1'b0;
    logic       reset_n;
    always #5 clock = ~clock;

    // Default instance (FLOW = 0)
    logic       enq_valid, enq_ready, deq_valid, deq_ready;
    logic [4:0] enq_bits, deq_bits;
    logic [1:0] count;
    logic       ram_W0_addr, ram_W0_en, ram_R0_addr, ram_R0_en;
    logic [4:0] ram_W0_data, ram_R0_data;
    logic [4:0] mem [2];

    queue_2x5_ctrl dut (
        .clock(clock), .reset_n(reset_n),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_bits(enq_bits),
        .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_bits(deq_bits),
        .count(count),
        .ram_W0_addr(ram_W0_addr), .ram_W0_en(ram_W0_en), .ram_W0_data(ram_W0_data),
        .ram_R0_addr(ram_R0_addr), .ram_R0_en(ram_R0_en), .ram_R0_data(ram_R0_data)
    );

    always @(posedge clock) if (ram_W0_en) mem[ram_W0_addr] <= ram_W0_data;
    assign ram_R0_data = ram_R0_en ? mem[ram_R0_addr] : 5'bx;

    // FLOW instance
    logic       f_enq_valid, f_enq_ready, f_deq_valid, f_deq_ready;
    logic [4:0] f_enq_bits, f_deq_bits;
    logic [1:0] f_count;
    logic       f_W0_addr, f_W0_en, f_R0_addr, f_R0_en;
    logic [4:0] f_W0_data, f_R0_data;
    logic [4:0] f_mem [2];

    queue_2x5_ctrl #(.FLOW(1'b1)) dut_flow (
        .clock(clock), .reset_n(reset_n),
        .enq_valid(f_enq_valid), .enq_ready(f_enq_ready), .enq_bits(f_enq_bits),
        .deq_valid(f_deq_valid), .deq_ready(f_deq_ready), .deq_bits(f_deq_bits),
        .count(f_count),
        .ram_W0_addr(f_W0_addr), .ram_W0_en(f_W0_en), .ram_W0_data(f_W0_data),
        .ram_R0_addr(f_R0_addr), .ram_R0_en(f_R0_en), .ram_R0_data(f_R0_data)
    );

    always @(posedge clock) if (f_W0_en) f_mem[f_W0_addr] <= f_W0_data;
    assign f_R0_data = f_R0_en ? f_mem[f_R0_addr] : 5'bx;

    int checks = 0;
    int errors = 0;
    logic [4:0] sb [$];
    int   m_count;
    logic m_wptr, m_rptr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_count = 0;
        m_wptr  = 1'b0;
        m_rptr  = 1'b0;
        sb.delete();
    endtask

    // One clock cycle on the FLOW=0 instance: drive, check at negedge, advance model.
    task automatic cycle(input logic ev, input logic [4:0] eb, input logic dr);
        logic exp_enq, exp_deq;
        enq_valid = ev;
        enq_bits  = eb;
        deq_ready = dr;
        @(negedge clock);
        exp_enq = ev && (m_count != 2);
        exp_deq = dr && (m_count != 0);
        check("enq_ready", 32'(enq_ready), 32'(m_count != 2));
        check("deq_valid", 32'(deq_valid), 32'(m_count != 0));
        check("count",     32'(count),     32'(m_count));
        check("w0_en",     32'(ram_W0_en), 32'(exp_enq));
        check("r0_en",     32'(ram_R0_en), 32'(m_count != 0));
        if (exp_enq) check("w0_addr", 32'(ram_W0_addr), 32'(m_wptr));
        if (m_count != 0) check("r0_addr", 32'(ram_R0_addr), 32'(m_rptr));
        if (exp_deq) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL scoreboard: observed dequeue expected none");
            end else begin
                check("deq_bits", 32'(deq_bits), 32'(sb.pop_front()));
            end
        end
        if (exp_enq) sb.push_back(eb);
        if (exp_enq) m_wptr = ~m_wptr;
        if (exp_deq) m_rptr = ~m_rptr;
        m_count = m_count + int'(exp_enq) - int'(exp_deq);
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        enq_valid = 1'b0; enq_bits = '0; deq_ready = 1'b0;
        f_enq_valid = 1'b0; f_enq_bits = '0; f_deq_ready = 1'b0;
        model_reset();
        #12;
        check("rst_enq_ready", 32'(enq_ready), 32'd1);
        check("rst_deq_valid", 32'(deq_valid), 32'd0);
        check("rst_count",     32'(count),     32'd0);
        check("rst_w0_en",     32'(ram_W0_en), 32'd0);
        check("rst_r0_en",     32'(ram_R0_en), 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;

        // Fill, then a refused third enqueue
        cycle(1'b1, 5'h0A, 1'b0);
        cycle(1'b1, 5'h15, 1'b0);
        cycle(1'b1, 5'h03, 1'b0);
        // Drain
        cycle(1'b0, 5'h00, 1'b1);
        cycle(1'b0, 5'h00, 1'b1);
        cycle(1'b0, 5'h00, 1'b1);

        // Hold count = 1 with simultaneous enq+deq, wrapping pointers
        cycle(1'b1, 5'h11, 1'b0);
        for (int i = 1; i <= 8; i++) cycle(1'b1, 5'(i), 1'b1);
        cycle(1'b0, 5'h00, 1'b1);
        cycle(1'b0, 5'h00, 1'b0);

        // Full + enq/deq together: enq refused, deq proceeds
        cycle(1'b1, 5'h1C, 1'b0);
        cycle(1'b1, 5'h07, 1'b0);
        cycle(1'b1, 5'h19, 1'b1);
        cycle(1'b1, 5'h0E, 1'b0);
        cycle(1'b0, 5'h00, 1'b1);
        cycle(1'b0, 5'h00, 1'b1);

        // Asynchronous reset mid-traffic
        cycle(1'b1, 5'h12, 1'b0);
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        f_enq_valid = 1'b1;
        f_enq_bits = 5'h05;
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_enq_ready", 32'(enq_ready),   32'd1);
        check("mid_rst_deq_valid", 32'(deq_valid),   32'd0);
        check("mid_rst_count",     32'(count),       32'd0);
        check("mid_rst_w0_en",     32'(ram_W0_en),   32'd0);
        check("mid_rst_r0_en",     32'(ram_R0_en),   32'd0);
        check("mid_rst_flow_dv",   32'(f_deq_valid), 32'd1);
        model_reset();
        f_enq_valid = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        cycle(1'b1, 5'h16, 1'b0);
        cycle(1'b0, 5'h00, 1'b1);
        cycle(1'b0, 5'h00, 1'b0);

        // FLOW bypass into an empty queue
        f_enq_valid = 1'b1; f_enq_bits = 5'h1F; f_deq_ready = 1'b1;
        #1;
        check("flow_deq_valid", 32'(f_deq_valid), 32'd1);
        check("flow_deq_bits",  32'(f_deq_bits),  32'h1F);
        check("flow_w0_en",     32'(f_W0_en),     32'd0);
        check("flow_count",     32'(f_count),     32'd0);
        @(posedge clock); #1;
        f_enq_valid = 1'b0; f_deq_ready = 1'b0;
        #1;
        check("flow_after_count", 32'(f_count),     32'd0);
        check("flow_after_dv",    32'(f_deq_valid), 32'd0);
        // FLOW with no consumer stores the word normally
        f_enq_valid = 1'b1; f_enq_bits = 5'h09;
        #1;
        check("flow_store_w0_en", 32'(f_W0_en), 32'd1);
        @(posedge clock); #1;
        f_enq_valid = 1'b0; f_deq_ready = 1'b1;
        #1;
        check("flow_store_count", 32'(f_count),    32'd1);
        check("flow_store_bits",  32'(f_deq_bits), 32'h09);
        @(posedge clock); #1;
        f_deq_ready = 1'b0;
        #1;
        check("flow_drained", 32'(f_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
